// File: rtl/gmm_log_pkg.sv
// Shared types, constants and the log2(1+m) table generator for the GMM float-to-log unit.
package gmm_log_pkg;

    localparam int LUT_BITS = 8;
    localparam int FRAC_W   = 16;
    localparam int OUT_W    = 8 + FRAC_W;
    localparam int LUT_N    = 2**LUT_BITS + 1;
    localparam int FP_BIAS  = 127;

    localparam logic [16:0]      LN2_Q16     = 17'd45426;
    localparam logic [OUT_W-1:0] LOG_POS_SAT = 24'h7FFFFF;
    localparam logic [OUT_W-1:0] LOG_NEG_SAT = 24'h800000;

    typedef logic signed [OUT_W-1:0] log_q_t;

    typedef struct packed {
        logic nan;
        logic neg_inf;
        logic pos_inf;
    } log_flags_t;

    typedef logic [LUT_N-1:0][FRAC_W:0] lut_t;

    // Integer-only log2 by repeated squaring, so the table elaborates without real math.
    function automatic logic [FRAC_W:0] log2_entry(input int i);
        longint unsigned x;
        longint unsigned r;
        if (i >= 2**LUT_BITS) return (FRAC_W+1)'(1 << FRAC_W);
        x = 64'(2**LUT_BITS + i) << (30 - LUT_BITS);
        r = 64'd0;
        for (int b = 0; b < FRAC_W + 4; b++) begin
            x = (x * x) >> 30;
            r = r << 1;
            if (x >= (64'd2 << 30)) begin
                x = x >> 1;
                r = r | 64'd1;
            end
        end
        return (FRAC_W+1)'((r + 64'd8) >> 4);
    endfunction

    function automatic lut_t build_lut();
        lut_t t;
        for (int i = 0; i < LUT_N; i++) t[i] = log2_entry(i);
        return t;
    endfunction

endpackage

// File: rtl/gmm_float_log_if.sv
// Streaming interface: float32 operand in, signed Q8.16 log result and special flags out.
interface gmm_float_log_if;
    import gmm_log_pkg::*;

    logic       in_valid;
    logic       in_ready;
    logic [31:0] in_data;
    logic       out_valid;
    logic       out_ready;
    log_q_t     out_log;
    log_flags_t out_flags;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_log, out_flags
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_log, out_flags
    );

endinterface

// File: rtl/gmm_log2_mant_rom.sv
// Dual-read registered ROM of log2(1+i/256) in Q0.16, returning L[idx] and L[idx+1].
module gmm_log2_mant_rom
    import gmm_log_pkg::*;
(
    input  logic                clk,
    input  logic                en,
    input  logic [LUT_BITS-1:0] idx,
    output logic [FRAC_W:0]     lo,
    output logic [FRAC_W:0]     hi
);

    localparam lut_t LUT = build_lut();

    // NOTE: ROM read registers carry no reset; the pipeline valid bits qualify them.
    always_ff @(posedge clk) begin
        if (en) begin
            lo <= LUT[idx];
            hi <= LUT[{1'b0, idx} + 9'd1];
        end
    end

endmodule

// File: rtl/gmm_float_log.sv
// Pipelined float32 -> Q8.16 log2 (3 stages); defining LOG_NATURAL_EN adds an ln(2) scale stage.
module gmm_float_log
    import gmm_log_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    gmm_float_log_if.slave  bus
);

    logic advance;
    assign advance     = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance;

    logic       in_sign;
    logic [7:0] in_exp;
    logic [22:0] in_man;
    log_flags_t in_flags;

    assign in_sign = bus.in_data[31];
    assign in_exp  = bus.in_data[30:23];
    assign in_man  = bus.in_data[22:0];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        in_flags = '0;
        if (in_exp == 8'hFF && in_man != '0)       in_flags.nan     = 1'b1;
        else if (in_sign && bus.in_data[30:0] != '0) in_flags.nan   = 1'b1;
        else if (in_exp == 8'hFF)                  in_flags.pos_inf = 1'b1;
        else if (in_exp == 8'h00)                  in_flags.neg_inf = 1'b1;
    end

    logic        s1_valid, s2_valid;
    logic [7:0]  s1_exp, s2_exp;
    logic [22:0] s1_man;
    logic [14:0] s2_f;
    log_flags_t  s1_flags, s2_flags;
    logic [FRAC_W:0] lut_lo, lut_hi;

    // NOTE: sequential state uses non-blocking assignments so all stages shift together.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (advance) begin
            s1_valid <= bus.in_valid;
            s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            s1_exp   <= in_exp;
            s1_man   <= in_man;
            s1_flags <= in_flags;
            s2_exp   <= s1_exp;
            s2_f     <= s1_man[14:0];
            s2_flags <= s1_flags;
        end
    end

    gmm_log2_mant_rom u_rom (
        .clk (clk),
        .en  (advance),
        .idx (s1_man[22:15]),
        .lo  (lut_lo),
        .hi  (lut_hi)
    );

    logic [FRAC_W:0] lut_diff;
    logic [31:0]     interp_prod;
    logic [FRAC_W:0] frac;
    logic [OUT_W-1:0] log2_raw;
    log_q_t          log2_val;

    always_comb begin
        lut_diff    = lut_hi - lut_lo;
        interp_prod = 32'(lut_diff) * 32'(s2_f) + 32'd16384;
        frac        = lut_lo + (FRAC_W+1)'(interp_prod >> 15);
        log2_raw    = ((OUT_W'(s2_exp) - OUT_W'(FP_BIAS)) << FRAC_W) + OUT_W'(frac);
        if (s2_flags.nan || s2_flags.pos_inf) log2_val = LOG_POS_SAT;
        else if (s2_flags.neg_inf)            log2_val = LOG_NEG_SAT;
        else                                  log2_val = log2_raw;
    end

    logic       fin_valid;
    log_q_t     fin_log;
    log_flags_t fin_flags;

`ifdef LOG_NATURAL_EN
    logic       s3_valid;
    log_q_t     s3_log;
    log_flags_t s3_flags;
    logic signed [42:0] q_ext, k_ext, ln_prod;

    always_ff @(posedge clk) begin
        if (rst)          s3_valid <= 1'b0;
        else if (advance) s3_valid <= s2_valid;
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            s3_log   <= log2_val;
            s3_flags <= s2_flags;
        end
    end

    // Special codes bypass the scale so both builds report identical saturation values.
    always_comb begin
        q_ext   = 43'(s3_log);
        k_ext   = 43'(LN2_Q16);
        ln_prod = q_ext * k_ext + 43'sd32768;
        if (s3_flags != '0) fin_log = s3_log;
        else                fin_log = OUT_W'(ln_prod >>> FRAC_W);
    end

    assign fin_valid = s3_valid;
    assign fin_flags = s3_flags;
`else
    assign fin_valid = s2_valid;
    assign fin_log   = log2_val;
    assign fin_flags = s2_flags;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_log   <= '0;
            bus.out_flags <= '0;
        end else if (advance) begin
            bus.out_valid <= fin_valid;
            bus.out_log   <= fin_log;
            bus.out_flags <= fin_flags;
        end
    end

endmodule

// File: tb/tb_gmm_float_log.sv
// Self-checking bench for gmm_float_log against a real-arithmetic log model; honours LOG_NATURAL_EN.
module tb_gmm_float_log;
    import gmm_log_pkg::*;

`ifdef LOG_NATURAL_EN
    localparam int LAT = 4;
    localparam logic [23:0] EXP_ONE   = 24'h000000;
    localparam logic [23:0] EXP_TWO   = 24'h00B172;
    localparam logic [23:0] EXP_HALF  = 24'hFF4E8E;
    localparam logic [23:0] EXP_THREE = 24'h01193E;
`else
    localparam int LAT = 3;
    localparam logic [23:0] EXP_ONE   = 24'h000000;
    localparam logic [23:0] EXP_TWO   = 24'h010000;
    localparam logic [23:0] EXP_HALF  = 24'hFF0000;
    localparam logic [23:0] EXP_THREE = 24'h0195C0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gmm_float_log_if bus ();

    gmm_float_log dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference: exact log from the float value, rounded to Q8.16 (then scaled by the Q16 ln2).
    function automatic void model(input logic [31:0] x, output int eq, output logic [2:0] ef);
        int  e;
        int  m;
        real l2;
        e  = int'(x[30:23]);
        m  = int'(x[22:0]);
        ef = 3'b000;
        eq = 0;
        if (e == 255 && m != 0)                 ef = 3'b100;
        else if (x[31] && x[30:0] != 31'd0)     ef = 3'b100;
        else if (e == 255)                      ef = 3'b001;
        else if (e == 0)                        ef = 3'b010;
        if (ef[2] || ef[0])  eq = 8388607;
        else if (ef[1])      eq = -8388608;
        else begin
            l2 = real'(e - 127) + $ln(1.0 + real'(m) / 8388608.0) / $ln(2.0);
            l2 = $floor(l2 * 65536.0 + 0.5);
`ifdef LOG_NATURAL_EN
            l2 = $floor(l2 * 45426.0 / 65536.0 + 0.5);
`endif
            eq = int'(l2);
        end
    endfunction

    function automatic bit result_ok(input logic [23:0] lv, input logic [2:0] fv,
                                     input int eq, input logic [2:0] ef);
        int act;
        if ($isunknown({lv, fv})) return 1'b0;
        if (fv !== ef) return 1'b0;
        if (ef != 3'b000) return lv === eq[23:0];
        act = {{8{lv[23]}}, lv};
        return (act - eq <= 2) && (eq - act <= 2);
    endfunction

    function automatic logic [31:0] rand_normal();
        logic [7:0]  e;
        logic [22:0] m;
        e = 8'($urandom_range(1, 253));
        m = 23'($urandom);
        return {1'b0, e, m};
    endfunction

    // One word through an empty pipeline with out_ready high; reports result and measured latency.
    task automatic xfer(input logic [31:0] word, output logic [23:0] lv,
                        output logic [2:0] fv, output int lat);
        @(posedge clk); #1;
        bus.in_data   = word;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        #1;
        lat = -1;
        lv  = 'x;
        fv  = 'x;
        for (int c = 1; c <= 20; c++) begin
            if (bus.out_valid === 1'b1) begin
                lat = c;
                lv  = bus.out_log;
                fv  = bus.out_flags;
                break;
            end
            @(posedge clk); #2;
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
        end
        checks++;
        if (bus.out_log !== 24'h000000) begin
            errors++; $display("FAIL reset_out_log got=%h want=000000", bus.out_log);
        end
        checks++;
        if (bus.out_flags !== 3'b000) begin
            errors++; $display("FAIL reset_out_flags got=%b want=000", bus.out_flags);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] words [4] = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'h40400000};
        logic [23:0] exps  [4] = '{EXP_ONE, EXP_TWO, EXP_HALF, EXP_THREE};
        logic [23:0] lv;
        logic [2:0]  fv;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            xfer(words[i], lv, fv, lat);
            checks++;
            if (lat != LAT) begin
                errors++; $display("FAIL directed_latency in=%h got=%0d want=%0d", words[i], lat, LAT);
            end
            checks++;
            if (lv !== exps[i] || fv !== 3'b000) begin
                errors++;
                $display("FAIL directed_value in=%h got=%h/%b want=%h/000", words[i], lv, fv, exps[i]);
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] words [7] = '{32'h00000000, 32'h80000000, 32'hBF800000, 32'h7F800000,
                                   32'h7FC00000, 32'h00000001, 32'hFF800000};
        logic [23:0] exp_l [7] = '{24'h800000, 24'h800000, 24'h7FFFFF, 24'h7FFFFF,
                                   24'h7FFFFF, 24'h800000, 24'h7FFFFF};
        logic [2:0]  exp_f [7] = '{3'b010, 3'b010, 3'b100, 3'b001, 3'b100, 3'b010, 3'b100};
        logic [23:0] lv;
        logic [2:0]  fv;
        int          lat;
        for (int i = 0; i < 7; i++) begin
            xfer(words[i], lv, fv, lat);
            checks++;
            if (lv !== exp_l[i] || fv !== exp_f[i]) begin
                errors++;
                $display("FAIL special in=%h got=%h/%b want=%h/%b lat=%0d",
                         words[i], lv, fv, exp_l[i], exp_f[i], lat);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic [23:0] lv;
        logic [2:0]  fv;
        int          lat;
        int          eq;
        logic [2:0]  ef;
        for (int i = 0; i < 100; i++) begin
            w = rand_normal();
            xfer(w, lv, fv, lat);
            model(w, eq, ef);
            checks++;
            if (!result_ok(lv, fv, eq, ef)) begin
                errors++;
                $display("FAIL random in=%h got=%h/%b want=%h/%b (+-2) lat=%0d",
                         w, lv, fv, eq[23:0], ef, lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [16];
        logic [31:0] pending [$];
        logic [31:0] w;
        logic [23:0] prev_log;
        logic [2:0]  prev_flags;
        bit          prev_stall;
        int          sent;
        int          got;
        int          extra;
        int          eq;
        logic [2:0]  ef;
        for (int i = 0; i < 16; i++) words[i] = rand_normal();
        sent       = 0;
        got        = 0;
        prev_stall = 1'b0;
        prev_log   = '0;
        prev_flags = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (LAT + 2) @(posedge clk);
        for (int cyc = 0; cyc < 300 && got < 16; cyc++) begin
            @(posedge clk); #1;
            bus.in_valid  = (sent < 16);
            bus.in_data   = (sent < 16) ? words[sent] : 32'h0;
            bus.out_ready = (cyc < 10) ? (cyc % 2 == 0) : (cyc < 15) ? 1'b0 : 1'b1;
            #1;
            if (prev_stall) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_log !== prev_log || bus.out_flags !== prev_flags) begin
                    errors++;
                    $display("FAIL b2b_stall_stable cyc=%0d got=%b/%h/%b want=1/%h/%b", cyc,
                             bus.out_valid, bus.out_log, bus.out_flags, prev_log, prev_flags);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0) begin
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++; $display("FAIL b2b_in_ready_stalled cyc=%0d got=%b want=0", cyc, bus.in_ready);
                end
            end
            if (bus.in_valid && bus.in_ready === 1'b1) begin
                pending.push_back(words[sent]);
                sent++;
            end
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                checks++;
                if (pending.size() == 0) begin
                    errors++; $display("FAIL b2b_spurious cyc=%0d got=%h want=none", cyc, bus.out_log);
                end else begin
                    w = pending.pop_front();
                    model(w, eq, ef);
                    if (!result_ok(bus.out_log, bus.out_flags, eq, ef)) begin
                        errors++;
                        $display("FAIL b2b_order cyc=%0d in=%h got=%h/%b want=%h/%b (+-2)",
                                 cyc, w, bus.out_log, bus.out_flags, eq[23:0], ef);
                    end
                end
                got++;
            end
            prev_stall = (bus.out_valid === 1'b1) && !bus.out_ready;
            prev_log   = bus.out_log;
            prev_flags = bus.out_flags;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        extra = 0;
        repeat (LAT + 3) begin
            @(posedge clk); #2;
            if (bus.out_valid !== 1'b0) extra++;
        end
        checks++;
        if (sent != 16 || got != 16 || pending.size() != 0 || extra != 0) begin
            errors++;
            $display("FAIL b2b_count sent=%0d got=%0d left=%0d extra=%0d want=16/16/0/0",
                     sent, got, pending.size(), extra);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.in_data  = 32'h40000000 + (32'(k) << 20);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_state got=%b/%b want=out_valid 0 in_ready 1", bus.out_valid, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #2;
            if (bus.out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL midreset_leak got=%0d outputs want=0", seen);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_specials();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
